// File: rtl/vga_write_queue_if.sv
// AHB-Lite slave-side signal bundle for the VGA write-posting queue.
// The master modport is the bus side, and the slave modport is the queue side.
interface vga_write_queue_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HWRITE, HTRANS, HREADY, HWDATA,
        input  HREADYOUT, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HWRITE, HTRANS, HREADY, HWDATA,
        output HREADYOUT, HRDATA
    );
endinterface

// File: rtl/vga_write_queue.sv
// Write-posting queue between AHB-Lite and the VGA console/image write ports.
// It captures bus writes into an in-order FIFO and drains one entry per cycle.
// Console entries wait while the console scrolls. A blocked console head also
// holds back the image entries queued behind it, so the queue stays in order.
module vga_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    vga_write_queue_if.slave ahb,
    input  logic             scroll,
    output logic             console_write,
    output logic [7:0]       console_wdata,
    output logic             image_write,
    output logic [13:0]      image_addr,
    output logic [7:0]       image_wdata
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef struct packed {
        logic        is_console;
        logic [13:0] addr;
        logic [7:0]  data;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          sel_q;
    logic          write_q;
    logic          trans_q;
    logic [23:0]   addr_q;

    logic          empty;
    logic          full;
    logic          live;
    logic          push;
    logic          pop;
    entry_t        head;
    entry_t        wr_entry;

    // These bus bits carry nothing this block decodes.
    logic          unused_bits;
    assign unused_bits = ^{ahb.HADDR[31:24], ahb.HWDATA[31:8], ahb.HTRANS[0]};

    assign empty    = (count == '0);
    assign full     = (count == FULL_COUNT);
    assign head     = mem[rd_ptr];
    assign live     = sel_q & trans_q;

    // A console head waits out a scroll, and everything behind it waits too.
    assign pop      = !empty && !(head.is_console && scroll);

    // A full queue can still take a write in the same cycle that an entry drains.
    assign ahb.HREADYOUT = !(full && !pop);
    assign push     = live & write_q & ahb.HREADYOUT;

    assign wr_entry = '{is_console: (addr_q == 24'h0),
                        addr:       addr_q[15:2],
                        data:       ahb.HWDATA[7:0]};

    assign ahb.HRDATA = {16'h0, 8'(count), 5'h0, scroll, full, empty};

    // Capture the address phase whenever the bus accepts one.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_q   <= 1'b0;
            write_q <= 1'b0;
            trans_q <= 1'b0;
            addr_q  <= '0;
        end else if (ahb.HREADY) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            sel_q   <= ahb.HSEL;
            write_q <= ahb.HWRITE;
            trans_q <= ahb.HTRANS[1];
            addr_q  <= ahb.HADDR[23:0];
        end
    end

    // Storage for queued entries.
    always_ff @(posedge HCLK) begin
        // NOTE: storage is not reset; count and pointers alone decide which slots are valid.
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Register the write strobes and data for the entry drained this cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            console_write <= 1'b0;
            console_wdata <= '0;
            image_write   <= 1'b0;
            image_addr    <= '0;
            image_wdata   <= '0;
        end else begin
            console_write <= pop & head.is_console;
            image_write   <= pop & !head.is_console;
            console_wdata <= (pop && head.is_console)  ? head.data : 8'h00;
            image_wdata   <= (pop && !head.is_console) ? head.data : 8'h00;
            if (pop && !head.is_console) begin
                image_addr <= head.addr;
            end
        end
    end
endmodule
